// File: rtl/link_rx_deframer.sv
// link_rx_deframer -- byte-stream frame receiver feeding a 32-entry word FIFO.
//
// Frame: 0x7E, header {cmd[1:0], n[5:0]}, 2n payload bytes (MSB byte first),
// optional checksum byte (XOR of header and payload).
// Payload words are written speculatively and only become visible to the
// session once the frame is complete (and its checksum matched).
//
// Configuration macro: DEFRAME_CHECKSUM_EN
//   defined   -> frames carry a checksum byte, mismatches pulse chkErr
//   undefined -> no checksum byte, chkErr tied low, no XOR logic built

module link_rx_deframer (
    input  logic        clk,
    input  logic        reset,
    input  logic        rcvSignal,
    input  logic [7:0]  packetIn,
    input  logic        sessionBusy,
    output logic [1:0]  sendingToSession,
    output logic [15:0] data,
    output logic [5:0]  rcv_data_count,
    output logic        chkErr,
    output logic        dropErr
);

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        HEADER = 3'd1,
        PAY_HI = 3'd2,
        PAY_LO = 3'd3,
        CHECK  = 3'd4,
        COMMIT = 3'd5
    } state_t;

    localparam logic [7:0] SOF_BYTE   = 8'h7E;
    localparam logic [5:0] MAX_WORDS  = 6'd32;
    localparam logic [5:0] FIFO_DEPTH = 6'd32;

`ifdef DEFRAME_CHECKSUM_EN
    // Running checksum update: XOR of every header and payload byte.
    function automatic logic [7:0] xor_accumulate(input logic [7:0] acc,
                                                  input logic [7:0] next_byte);
        xor_accumulate = acc ^ next_byte;
    endfunction
`endif

    // FSM state
    state_t      state;
    state_t      state_next;

    // Frame fields captured while receiving
    logic [1:0]  frame_cmd;
    logic [5:0]  remaining;
    logic [7:0]  hi_byte;
    logic        empty_frame;

    // FIFO storage and pointers (6-bit, wrap bit distinguishes full/empty)
    logic [17:0] mem [0:31];
    logic [5:0]  rd_ptr;
    logic [5:0]  wr_ptr;       // committed write pointer
    logic [5:0]  spec_ptr;     // speculative write pointer
    logic [5:0]  rd_ptr_next;
    logic [5:0]  wr_ptr_next;
    logic [5:0]  spec_ptr_next;

    // Decoded header and space bookkeeping
    logic [1:0]  hdr_cmd;
    logic [5:0]  hdr_words;
    logic [5:0]  hdr_need;
    logic [5:0]  occupied;
    logic [5:0]  free_space;

    // Per-cycle actions from the FSM
    logic        pay_write;
    logic        commit_do;
    logic        drop_pulse;
    logic        pop;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [17:0] mem_din;
    logic [17:0] head;

`ifdef DEFRAME_CHECKSUM_EN
    logic [7:0]  csum;
    logic        chk_pulse;
    logic        rollback;
`endif

    assign hdr_cmd   = packetIn[7:6];
    assign hdr_words = packetIn[5:0];
    // An empty frame still occupies one FIFO entry.
    assign hdr_need  = (hdr_words == 6'd0) ? 6'd1 : hdr_words;
    // Speculative entries count as occupied so a pending frame reserves its space.
    assign occupied   = spec_ptr - rd_ptr;
    assign free_space = FIFO_DEPTH - occupied;

    assign head = mem[rd_ptr[4:0]];
    assign pop  = (wr_ptr != rd_ptr) && !sessionBusy;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state decode and per-cycle action strobes.
    always_comb begin
        state_next = state;
        pay_write  = 1'b0;
        commit_do  = 1'b0;
        drop_pulse = 1'b0;
`ifdef DEFRAME_CHECKSUM_EN
        chk_pulse  = 1'b0;
        rollback   = 1'b0;
`endif
        case (state)
            HUNT: begin
                if (rcvSignal && (packetIn == SOF_BYTE)) begin
                    state_next = HEADER;
                end else begin
                    state_next = HUNT;
                end
            end
            HEADER: begin
                if (!rcvSignal) begin
                    state_next = HEADER;
                end else if ((hdr_cmd == 2'b00) || (hdr_words > MAX_WORDS)) begin
                    drop_pulse = 1'b1;
                    state_next = HUNT;
                end else if (free_space < hdr_need) begin
                    drop_pulse = 1'b1;
                    state_next = HUNT;
                end else if (hdr_words == 6'd0) begin
`ifdef DEFRAME_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = COMMIT;
`endif
                end else begin
                    state_next = PAY_HI;
                end
            end
            PAY_HI: begin
                if (rcvSignal) begin
                    state_next = PAY_LO;
                end else begin
                    state_next = PAY_HI;
                end
            end
            PAY_LO: begin
                if (!rcvSignal) begin
                    state_next = PAY_LO;
                end else if (remaining == 6'd1) begin
                    pay_write  = 1'b1;
`ifdef DEFRAME_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = COMMIT;
`endif
                end else begin
                    pay_write  = 1'b1;
                    state_next = PAY_HI;
                end
            end
            CHECK: begin
`ifdef DEFRAME_CHECKSUM_EN
                if (!rcvSignal) begin
                    state_next = CHECK;
                end else if (packetIn == csum) begin
                    state_next = COMMIT;
                end else begin
                    chk_pulse  = 1'b1;
                    rollback   = 1'b1;
                    state_next = HUNT;
                end
`else
                state_next = HUNT;
`endif
            end
            COMMIT: begin
                // Single-cycle commit; any byte arriving now is ignored.
                commit_do  = 1'b1;
                state_next = HUNT;
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // Next values of the three FIFO pointers.
    always_comb begin
        rd_ptr_next   = rd_ptr;
        wr_ptr_next   = wr_ptr;
        spec_ptr_next = spec_ptr;

        if (pop) begin
            rd_ptr_next = rd_ptr + 6'd1;
        end else begin
            rd_ptr_next = rd_ptr;
        end

`ifdef DEFRAME_CHECKSUM_EN
        if (rollback) begin
            spec_ptr_next = wr_ptr;
        end else
`endif
        if (pay_write || (commit_do && empty_frame)) begin
            spec_ptr_next = spec_ptr + 6'd1;
        end else begin
            spec_ptr_next = spec_ptr;
        end

        if (commit_do && empty_frame) begin
            wr_ptr_next = spec_ptr + 6'd1;
        end else if (commit_do) begin
            wr_ptr_next = spec_ptr;
        end else begin
            wr_ptr_next = wr_ptr;
        end
    end

    // FIFO write port selection: payload words, or the zero-data entry of an empty frame.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = spec_ptr[4:0];
        mem_din  = 18'd0;
        if (pay_write) begin
            mem_we  = 1'b1;
            mem_din = {frame_cmd, hi_byte, packetIn};
        end else if (commit_do && empty_frame) begin
            mem_we  = 1'b1;
            mem_din = {frame_cmd, 16'h0000};
        end else begin
            mem_we  = 1'b0;
        end
    end

    // FIFO storage; contents are invalidated by the pointers, not cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    // Pointer registers and the committed-entry count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr         <= 6'd0;
            wr_ptr         <= 6'd0;
            spec_ptr       <= 6'd0;
            rcv_data_count <= 6'd0;
        end else begin
            rd_ptr         <= rd_ptr_next;
            wr_ptr         <= wr_ptr_next;
            spec_ptr       <= spec_ptr_next;
            rcv_data_count <= wr_ptr_next - rd_ptr_next;
        end
    end

    // Capture header fields and the pending high byte of each word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cmd   <= 2'b00;
            remaining   <= 6'd0;
            hi_byte     <= 8'h00;
            empty_frame <= 1'b0;
        end else begin
            case (state)
                HEADER: begin
                    if (rcvSignal) begin
                        frame_cmd   <= hdr_cmd;
                        remaining   <= hdr_words;
                        empty_frame <= (hdr_words == 6'd0);
                    end
                end
                PAY_HI: begin
                    if (rcvSignal) begin
                        hi_byte <= packetIn;
                    end
                end
                PAY_LO: begin
                    if (rcvSignal) begin
                        remaining <= remaining - 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DEFRAME_CHECKSUM_EN
    // Running XOR of header and payload bytes for the checksum compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= 8'h00;
        end else begin
            case (state)
                HEADER: begin
                    if (rcvSignal) begin
                        csum <= packetIn;
                    end
                end
                PAY_HI, PAY_LO: begin
                    if (rcvSignal) begin
                        csum <= xor_accumulate(csum, packetIn);
                    end
                end
                default: begin
                end
            endcase
        end
    end
`endif

    // Registered delivery to the session and one-cycle error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sendingToSession <= 2'b00;
            data             <= 16'h0000;
            chkErr           <= 1'b0;
            dropErr          <= 1'b0;
        end else begin
            if (pop) begin
                sendingToSession <= head[17:16];
                data             <= head[15:0];
            end else begin
                sendingToSession <= 2'b00;
                data             <= 16'h0000;
            end
`ifdef DEFRAME_CHECKSUM_EN
            chkErr  <= chk_pulse;
`else
            chkErr  <= 1'b0;
`endif
            dropErr <= drop_pulse;
        end
    end

endmodule

// File: doc/link_rx_deframer.md
LINK_RX_DEFRAMER -- requirements
Module: link_rx_deframer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low; 0 resets.
REQ-003 The block SHALL have port rcvSignal, input, 1 bit: byte strobe from the link; packetIn is valid in this cycle.
REQ-004 The block SHALL have port packetIn, input, 8 bits: link byte.
REQ-005 The block SHALL have port sessionBusy, input, 1 bit: the session cannot accept a word this cycle.
REQ-006 The block SHALL have port sendingToSession, output, 2 bits: command delivered to the session; 2'b00 means idle/no word.
REQ-007 The block SHALL have port data, output, 16 bits: word delivered with sendingToSession.
REQ-008 The block SHALL have port rcv_data_count, output, 6 bits: committed, undelivered FIFO entries (0..32).
REQ-009 The block SHALL have port chkErr, output, 1 bit: one-cycle pulse on a checksum failure.
REQ-010 The block SHALL have port dropErr, output, 1 bit: one-cycle pulse when a frame is discarded for an invalid header or lack of space.

Function
REQ-011 Frame format SHALL be:
- SOF byte 0x7E.
- Header byte: [7:6]=cmd, [5:0]=N words (0..32).
- 2N payload bytes, each word sent MSB byte first.
- Checksum byte: XOR of the header and all payload bytes.
REQ-012 The FSM SHALL have states HUNT, HEADER, PAY_HI, PAY_LO, CHECK, COMMIT, and SHALL advance only on cycles where rcvSignal=1, except COMMIT.
REQ-013 HUNT SHALL discard bytes until packetIn=0x7E, then go to HEADER.
REQ-014 HEADER SHALL latch cmd and N and go as follows:
- cmd=00, or N>32: pulse dropErr, go to HUNT.
- Free FIFO space < max(N,1): pulse dropErr, go to HUNT.
- N=0: go to CHECK.
- Otherwise: go to PAY_HI.
REQ-015 PAY_HI SHALL latch the high byte. PAY_LO SHALL write {cmd, hi, lo} at the speculative write pointer, decrement the remaining count, then go to CHECK when it reaches 0, else to PAY_HI.
REQ-016 Payload 0x7E bytes SHALL be treated as data; there is no escaping and no resynchronisation mid-frame.
REQ-017 CHECK SHALL compare packetIn to the running XOR:
- Match: go to COMMIT.
- Mismatch: restore the speculative write pointer to the committed write pointer, pulse chkErr, go to HUNT.
REQ-018 For an N=0 frame, COMMIT SHALL write one entry {cmd, 16'h0000}.
REQ-019 COMMIT SHALL copy the speculative pointer to the committed pointer in exactly one cycle, then go to HUNT. Bytes arriving during COMMIT are lost and are not an error.
REQ-020 The FIFO SHALL be 32 entries of 18 bits; pointers SHALL be 6 bits, using the wrap bit for the full/empty distinction.
REQ-021 Delivery SHALL happen on any cycle with committed entries and sessionBusy=0: sendingToSession/data present the head entry for exactly that cycle and the read pointer advances. Otherwise outputs SHALL be 00/16'h0000.
REQ-022 Delivery is registered: a checksum byte accepted in cycle t SHALL commit at t+1, and the first word SHALL appear no earlier than t+2.
REQ-023 A pop and a commit in the same cycle SHALL both take effect, and rcv_data_count SHALL reflect the net change.
REQ-024 Space checks SHALL count uncommitted speculative entries as occupied.

Reset
REQ-025 While reset=0, the block SHALL:
- Be in FSM state HUNT.
- Hold all pointers at 0 and rcv_data_count at 0.
- Drive sendingToSession=00, data=0, chkErr=0, dropErr=0.
REQ-026 Reset asserted mid-frame SHALL discard all partial and committed data; after release, the block SHALL wait for a new SOF.

Configuration
REQ-027 With `define DEFRAME_CHECKSUM_EN, the frame SHALL carry the checksum byte and CHECK SHALL operate as in REQ-017.
REQ-028 Without DEFRAME_CHECKSUM_EN:
- No checksum byte is expected.
- The last PAY_LO (or HEADER when N=0) SHALL go directly to COMMIT.
- chkErr SHALL be tied to 0.
- No XOR logic SHALL be built.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Valid frame 7E,82,12,34,AB,CD,chk=0x82^0x12^0x34^0xAB^0xCD, sessionBusy=0 -> two cycles out: (10,1234) then (10,ABCD); rcv_data_count peaks at 2.
- Same frame with a corrupted checksum (CHECKSUM_EN) -> chkErr pulses once, no words delivered, count stays 0.
- Frame 7E,C0,C0 (N=0, cmd=11) -> single output (11,0000).
- Fill the FIFO to 31 entries with sessionBusy=1, then send an N=2 frame -> dropErr pulse, count stays 31; release busy -> 31 words drain in order.
- Frame 7E,41,7E,7E,chk -> the 0x7E payload is treated as data, output (01,7E7E).
- reset=0 asserted mid-PAY_LO with 3 committed words -> outputs 0 and count 0 immediately; the next valid frame is received normally.
